// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback path: op codes, default widths and the buffered entry layout.
package alu_wb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_W   = 4;
    localparam int DEF_OP_W   = 4;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_ROR = 4'd5
    } op_e;

    // c_keep marks a ROR by zero whose carry is taken from flag_c at retire time.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_RD_W-1:0]   rd;
        logic                  we;
        logic                  setf;
        logic                  z;
        logic                  n;
        logic                  c;
        logic                  c_keep;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_flag_gen.sv
// Combinational Z/N/C generation for one ALU result, evaluated as the result is accepted.
module alu_flag_gen
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic [DATA_W-1:0] result_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [3:0]        shamt_i,
    input  logic              carry_i,
    input  logic              flag_c_i,
    output logic              z_o,
    output logic              n_o,
    output logic              c_o,
    output logic              c_keep_o
);

    logic is_ror;

    assign is_ror   = (op_i == OP_W'(OP_ROR));
    assign z_o      = (result_i == '0);
    assign n_o      = result_i[DATA_W-1];
    assign c_keep_o = is_ror && (shamt_i == 4'd0);
    // A right rotate leaves the last bit shifted out in the MSB.
    assign c_o      = c_keep_o ? flag_c_i :
                      is_ror   ? result_i[DATA_W-1] : carry_i;

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid buffer toward the register file, flag commit and retire counter.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [OP_W-1:0]   in_op,
    input  logic [3:0]        in_shamt,
    input  logic              in_carry,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic              in_setf,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic [CNT_W-1:0]  retired
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              we;
        logic              setf;
        logic              z;
        logic              n;
        logic              c;
        logic              c_keep;
    } entry_t;

    entry_t             main_q, main_d, skid_q, skid_d, new_entry;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_c_q, flag_c_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               accept, retire;
    logic               gen_z, gen_n, gen_c, gen_keep;

    alu_flag_gen #(.DATA_W(DATA_W), .OP_W(OP_W)) u_flag_gen (
        .result_i (in_result),
        .op_i     (in_op),
        .shamt_i  (in_shamt),
        .carry_i  (in_carry),
        .flag_c_i (flag_c_q),
        .z_o      (gen_z),
        .n_o      (gen_n),
        .c_o      (gen_c),
        .c_keep_o (gen_keep)
    );

    assign accept    = in_valid && in_ready_q && !flush;
    assign retire    = main_valid_q && wb_ready;
    assign new_entry = '{result: in_result, rd: in_rd, we: in_we, setf: in_setf,
                         z: gen_z, n: gen_n, c: gen_c, c_keep: gen_keep};

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || retire) begin
            // SKID is only ever valid behind a valid MAIN, and in_ready is low while it is.
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_comb begin
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        flag_c_d  = flag_c_q;
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + 1'b1;
            if (main_q.setf) begin
                flag_z_d = main_q.z;
                flag_n_d = main_q.n;
                // Preserved carry resolves here, after every older flag update has landed.
                flag_c_d = main_q.c_keep ? flag_c_q : main_q.c;
            end
        end
    end

    // NOTE: buffer payloads are reset too, because wb_* must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            retired_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge state.
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
            flag_c_q     <= flag_c_d;
            retired_q    <= retired_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wb_valid = main_valid_q;
    assign wb_we    = main_q.we;
    assign wb_rd    = main_q.rd;
    assign wb_data  = main_q.result;
    assign flag_z   = flag_z_q;
    assign flag_n   = flag_n_q;
    assign flag_c   = flag_c_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_wb_stage;
    import alu_wb_pkg::*;

    localparam int CW = 16;

    logic        clk, rst_n, flush, in_valid, in_ready, in_carry, in_we, in_setf;
    logic [15:0] in_result, wb_data;
    logic [3:0]  in_op, in_shamt, in_rd, wb_rd;
    logic        wb_valid, wb_ready, wb_we, flag_z, flag_n, flag_c;
    logic [15:0] retired;

    alu_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
        .in_shamt(in_shamt), .in_carry(in_carry), .in_rd(in_rd), .in_we(in_we), .in_setf(in_setf),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic [3:0]  rd;
        logic        we;
        logic        setf;
        logic [3:0]  op;
        logic [3:0]  shamt;
        logic        carry;
    } item_t;

    item_t mq[$];
    bit    mz, mn, mc;
    int    mret;
    int    checks, errors;

    function automatic logic [15:0] ror16(logic [15:0] v, int s);
        if (s == 0) return v;
        return (v >> s) | (v << (16 - s));
    endfunction

    task automatic drive(logic [3:0] op, logic [15:0] operand, logic [3:0] sh, logic cy,
                         logic [3:0] rd, logic we, logic setf);
        in_valid  = 1'b1;
        in_op     = op;
        in_shamt  = sh;
        in_result = (op == OP_ROR) ? ror16(operand, int'(sh)) : operand;
        in_carry  = cy;
        in_rd     = rd;
        in_we     = we;
        in_setf   = setf;
    endtask

    task automatic drive_random();
        logic [3:0] op;
        op = 4'($urandom_range(0, 5));
        drive(op, 16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom));
        if ($urandom_range(0, 7) == 0) in_result = 16'h0000;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // One clock: score the handshakes seen before the edge, then compare visible state after it.
    task automatic step(output bit acc);
        bit    ret;
        item_t it;
        acc = in_valid && in_ready && !flush;
        ret = wb_valid && wb_ready;
        if (ret) begin
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire: wb_data=%h with nothing outstanding", wb_data);
            end else begin
                it = mq.pop_front();
                if (wb_data !== it.result || wb_rd !== it.rd || wb_we !== it.we) begin
                    errors++;
                    $display("FAIL wb_payload: got data=%h rd=%0d we=%0b, expected data=%h rd=%0d we=%0b",
                             wb_data, wb_rd, wb_we, it.result, it.rd, it.we);
                end
                if (it.setf) begin
                    mz = (it.result == 16'h0000);
                    mn = it.result[15];
                    if (it.op == OP_ROR) begin
                        if (it.shamt != 4'd0) mc = it.result[15];
                    end else begin
                        mc = it.carry;
                    end
                end
            end
            mret = (mret + 1) % (1 << CW);
        end
        if (flush) begin
            mq.delete();
        end else if (acc) begin
            it = '{result: in_result, rd: in_rd, we: in_we, setf: in_setf,
                   op: in_op, shamt: in_shamt, carry: in_carry};
            mq.push_back(it);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wb_valid, in_ready, flag_z, flag_n, flag_c, retired} !==
            {mq.size() > 0, mq.size() < 2, mz, mn, mc, CW'(mret)}) begin
            errors++;
            $display("FAIL state: got valid=%0b ready=%0b z=%0b n=%0b c=%0b ret=%h, expected valid=%0b ready=%0b z=%0b n=%0b c=%0b ret=%h",
                     wb_valid, in_ready, flag_z, flag_n, flag_c, retired,
                     mq.size() > 0, mq.size() < 2, mz, mn, mc, CW'(mret));
        end
    endtask

    task automatic clear_model();
        mq.delete();
        mz = 0; mn = 0; mc = 0; mret = 0;
    endtask

    task automatic drain(input int budget);
        bit acc;
        idle();
        wb_ready = 1'b1;
        for (int i = 0; i < budget && mq.size() > 0; i++) step(acc);
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries still outstanding, expected 0", mq.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({wb_valid, in_ready, wb_we, wb_rd, wb_data, flag_z, flag_n, flag_c, retired} !==
            {1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: valid=%0b ready=%0b we=%0b rd=%0d data=%h z=%0b n=%0b c=%0b ret=%h",
                     wb_valid, in_ready, wb_we, wb_rd, wb_data, flag_z, flag_n, flag_c, retired);
        end
    endtask

    task automatic test_ror_basic();
        bit acc;
        wb_ready = 1'b1;
        drive(OP_ROR, 16'h0001, 4'd1, 1'b0, 4'd3, 1'b1, 1'b1);
        step(acc);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 16'h8000 || wb_rd !== 4'd3) begin
            errors++;
            $display("FAIL ror_output: valid=%0b data=%h rd=%0d, expected valid=1 data=8000 rd=3",
                     wb_valid, wb_data, wb_rd);
        end
        idle();
        step(acc);
        checks++;
        if ({flag_n, flag_z, flag_c} !== 3'b101 || retired !== 16'd1) begin
            errors++;
            $display("FAIL ror_flags: n=%0b z=%0b c=%0b ret=%0d, expected n=1 z=0 c=1 ret=1",
                     flag_n, flag_z, flag_c, retired);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int idx;
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        idx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            wb_ready = (cyc >= 3);
            if (idx < 3) drive(OP_ADD, vals[idx], 4'd0, 1'b0, 4'(idx + 1), 1'b1, 1'b0);
            else idle();
            step(acc);
            if (cyc == 2) begin
                checks++;
                if (acc) begin
                    errors++;
                    $display("FAIL third_held: third result accepted during stall, expected held upstream");
                end
            end
            if (acc) idx++;
            if (idx == 2 && cyc == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_drop: in_ready=%0b after second accept, expected 0", in_ready);
                end
            end
        end
        for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
            drive(OP_ADD, vals[idx], 4'd0, 1'b0, 4'(idx + 1), 1'b1, 1'b0);
            step(acc);
            if (acc) idx++;
        end
        drain(10);
    endtask

    task automatic test_carry_preserve();
        bit acc;
        wb_ready = 1'b1;
        drive(OP_ADD, 16'h0005, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
        step(acc);
        drain(5);
        wb_ready = 1'b0;
        drive(OP_ADD, 16'h1234, 4'd0, 1'b1, 4'd2, 1'b1, 1'b1);
        step(acc);
        drive(OP_ROR, 16'h0000, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        step(acc);
        drain(5);
        checks++;
        if ({flag_z, flag_n, flag_c} !== 3'b101) begin
            errors++;
            $display("FAIL carry_preserve: z=%0b n=%0b c=%0b, expected z=1 n=0 c=1",
                     flag_z, flag_n, flag_c);
        end
    endtask

    task automatic test_flush();
        bit acc;
        logic [2:0]  flags_before;
        logic [15:0] ret_before;
        wb_ready = 1'b0;
        drive_random(); step(acc);
        drive_random(); step(acc);
        checks++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: ready=%0b valid=%0b, expected ready=0 valid=1", in_ready, wb_valid);
        end
        flags_before = {flag_z, flag_n, flag_c};
        ret_before   = retired;
        drive_random();
        flush = 1'b1;
        step(acc);
        idle();
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1 ||
            {flag_z, flag_n, flag_c} !== flags_before || retired !== ret_before) begin
            errors++;
            $display("FAIL flush_result: valid=%0b ready=%0b flags=%b ret=%h, expected valid=0 ready=1 flags=%b ret=%h",
                     wb_valid, in_ready, {flag_z, flag_n, flag_c}, retired, flags_before, ret_before);
        end
        wb_ready = 1'b1;
        repeat (3) step(acc);
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 400; i++) begin
            wb_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0) drive_random();
            else in_valid = 1'b0;
            flush = ($urandom_range(0, 49) == 0);
            step(acc);
        end
        drain(10);
    endtask

    task automatic test_wrap();
        bit acc;
        int cyc;
        wb_ready = 1'b1;
        cyc = 0;
        while (mret != 16'hFFFF && cyc < 70000) begin
            drive_random();
            step(acc);
            cyc++;
        end
        checks++;
        if (mret != 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_timeout: retired=%h after %0d cycles, expected ffff", retired, cyc);
        end
        idle();
        step(acc);
        checks++;
        if (retired !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: retired=%h, expected 0000", retired);
        end
        drain(5);
    endtask

    task automatic test_async_reset();
        bit acc;
        wb_ready = 1'b0;
        drive(OP_ROR, 16'h00F0, 4'd4, 1'b0, 4'd7, 1'b1, 1'b1); step(acc);
        drive(OP_SUB, 16'h8001, 4'd0, 1'b1, 4'd9, 1'b1, 1'b1); step(acc);
        idle();
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        checks++;
        if ({wb_valid, in_ready, wb_we, wb_rd, wb_data, flag_z, flag_n, flag_c, retired} !==
            {1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: valid=%0b ready=%0b we=%0b rd=%0d data=%h z=%0b n=%0b c=%0b ret=%h",
                     wb_valid, in_ready, wb_we, wb_rd, wb_data, flag_z, flag_n, flag_c, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_ready = 1'b1;
        drive_random(); step(acc);
        drain(5);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        clear_model();
        rst_n     = 1'b0;
        wb_ready  = 1'b0;
        in_result = '0; in_op = '0; in_shamt = '0; in_carry = 1'b0;
        in_rd     = '0; in_we = 1'b0; in_setf = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ror_basic();
        test_back_to_back();
        test_carry_preserve();
        test_flush();
        test_random();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
